// File: rtl/op_sequencer_pkg.sv
// op_sequencer_pkg
//   Definitions shared by the command sequencer and the matrix controller.
//   Both blocks take opcodes and chunk-field positions from this package,
//   so they decode a command word the same way.
//   Contents: opcode constants, the sequencer state enum and the bit
//   ranges of the chunk fields.
package op_sequencer_pkg;

  // Opcodes carried in bits [3:0] of a command or operation word.
  localparam logic [3:0] OP_IDLE   = 4'd0;
  localparam logic [3:0] OP_MATMUL = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;

  // Bit ranges of the chunk fields.
  localparam int FLD_OPCODE_LSB = 0;
  localparam int FLD_OPCODE_MSB = 3;
  localparam int FLD_OP_A_LSB   = 4;
  localparam int FLD_OP_A_MSB   = 7;
  localparam int FLD_OP_B_LSB   = 8;
  localparam int FLD_OP_B_MSB   = 11;
  localparam int FLD_OP_C_LSB   = 12;
  localparam int FLD_OP_C_MSB   = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MATMUL,
    ST_DRAIN,
    ST_WRITE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/op_sequencer.sv
// op_sequencer
//   Command-issue stage in front of the matrix controller. The block takes
//   host commands one at a time and turns each one into a correctly timed
//   operation/in_data sequence:
//   - A multiply holds its opcode for MM_CYCLES cycles, then idles for
//     DRAIN_CYCLES cycles.
//   - A write presents one word per accepted host data word,
//     WRITE_WORDS words in total.
//   - Opcode 0 and illegal opcodes are consumed in a single cycle.
//   - A zero operation cycle always separates two issued commands.
// Ports:
//   clk, reset      clock; synchronous active-high reset (overrides enable)
//   enable          global enable; when low, state freezes and handshakes drop
//   cmd_valid/cmd   host command stream; cmd_ready is the accept strobe
//   data_valid/data host write-word stream; data_ready is the accept strobe
//   operation       registered operation word to the controller
//   in_data         registered write data to the controller
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse when a command completes
//   err             one-cycle pulse when an illegal opcode is consumed
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int unsigned MM_CYCLES    = 320,
  parameter int unsigned DRAIN_CYCLES = 24,
  parameter int unsigned WRITE_WORDS  = 80,
  parameter int unsigned CNT_W        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [31:0] cmd,
  output logic        cmd_ready,
  input  logic        data_valid,
  input  logic [31:0] data,
  output logic        data_ready,
  output logic [31:0] operation,
  output logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W-1:0] MM_LAST    = CNT_W'(MM_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WRITE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cmd_q;
  logic             done_q;
  logic             err_q;
  logic [3:0]       cmd_opcode;

  assign cmd_opcode = cmd[FLD_OPCODE_MSB:FLD_OPCODE_LSB];

  assign cmd_ready  = enable && (state == ST_IDLE);
  assign data_ready = enable && (state == ST_WRITE);
  assign busy       = (state != ST_IDLE);
  // The pulses are held while frozen and shown once enable returns.
  assign done       = done_q && enable;
  assign err        = err_q && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      operation <= '0;
      in_data   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (enable) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          operation <= '0;
          if (cmd_valid) begin
            cmd_q <= cmd;
            case (cmd_opcode)
              OP_MATMUL: begin
                // The first multiply cycle is the cycle after accept, so it counts as 1.
                operation <= cmd;
                cnt       <= CNT_ONE;
                state     <= ST_MATMUL;
              end
              OP_WRITE: begin
                cnt   <= '0;
                state <= ST_WRITE;
              end
              OP_IDLE: done_q <= 1'b1;
              default: err_q  <= 1'b1;
            endcase
          end
        end
        ST_MATMUL: begin
          if (cnt == MM_LAST) begin
            operation <= '0;
            cnt       <= CNT_ONE;
            state     <= ST_DRAIN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt    <= '0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_WRITE: begin
          // The write opcode is shown only with a freshly accepted word.
          if (data_valid) begin
            operation <= cmd_q;
            in_data   <= data;
            if (cnt == WR_LAST) begin
              cnt   <= '0;
              state <= ST_GAP;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            operation <= '0;
          end
        end
        ST_GAP: begin
          // The last write word is on the outputs in this cycle. The next
          // cycle drives operation 0 and pulses done, then idles.
          operation <= '0;
          done_q    <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          operation <= '0;
          cnt       <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
